// File: rtl/imem_boot_loader.sv
// imem_boot_loader
// Receives a framed program image (count lo, count hi, 4*N payload bytes,
// checksum) over a valid/ready byte stream. It assembles little-endian
// 32-bit words and writes them to instruction memory, then releases the
// core (resetpc) once the checksum has been verified.
// 4*MAX_WORDS must not exceed 2**ADDR_W, so that every word address fits.
module imem_boot_loader #(
    parameter int ADDR_W    = 9,
    parameter int MAX_WORDS = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              we0,
    output logic [ADDR_W-1:0] wr_addr0,
    output logic [31:0]       wr_din0,
    output logic              resetpc,
    output logic              busy,
    output logic              error
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR1 = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    state_t              state_q,  state_d;
    logic [7:0]          cnt_lo_q, cnt_lo_d;
    logic [IDX_W-1:0]    last_q,   last_d;
    logic [IDX_W-1:0]    idx_q,    idx_d;
    logic [1:0]          bsel_q,   bsel_d;
    logic [23:0]         asm_q,    asm_d;
    logic [7:0]          sum_q,    sum_d;
    logic                we_q,     we_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [31:0]         din_q,    din_d;
    logic                rdy_q,    rdy_d;
    logic                busy_q,   busy_d;
    logic                rpc_q,    rpc_d;
    logic                err_q,    err_d;

    logic                accept_s;
    logic [15:0]         count_s;

    // A byte is consumed only when offered while the registered ready is high.
    assign accept_s = rx_valid & rdy_q;
    // Full 16-bit word count, valid while the high count byte is on rx_data.
    assign count_s  = {rx_data, cnt_lo_q};

    // Next-state logic: frame parsing, word assembly, checksum and status.
    always_comb begin
        state_d  = state_q;
        cnt_lo_d = cnt_lo_q;
        last_d   = last_q;
        idx_d    = idx_q;
        bsel_d   = bsel_q;
        asm_d    = asm_q;
        sum_d    = sum_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        din_d    = din_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_lo_d = rx_data;
                    sum_d    = sum_q + rx_data;
                    state_d  = ST_HDR1;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_HDR1: begin
                if (accept_s) begin
                    sum_d = sum_q + rx_data;
                    if ((count_s == 16'd0) || (count_s > 16'(MAX_WORDS))) begin
                        state_d = ST_ERR;
                    end else begin
                        last_d  = IDX_W'(count_s - 16'd1);
                        idx_d   = '0;
                        bsel_d  = 2'd0;
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_HDR1;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    sum_d = sum_q + rx_data;
                    if (bsel_q == 2'd3) begin
                        // Fourth byte completes the word: issue the write now.
                        we_d   = 1'b1;
                        addr_d = ADDR_W'({idx_q, 2'b00});
                        din_d  = {rx_data, asm_q};
                        bsel_d = 2'd0;
                        if (idx_q == last_q) begin
                            state_d = ST_CHK;
                        end else begin
                            idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        // Shift right so the first byte ends up as the LSB.
                        asm_d  = {rx_data, asm_q[23:8]};
                        bsel_d = bsel_q + 2'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CHK: begin
                if (accept_s) begin
                    if (rx_data == sum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = ST_CHK;
                end
            end
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase

        // Status outputs are decoded from the next state and registered.
        rdy_d  = (state_d == ST_IDLE) || (state_d == ST_HDR1) ||
                 (state_d == ST_DATA) || (state_d == ST_CHK);
        busy_d = (state_d == ST_HDR1) || (state_d == ST_DATA) ||
                 (state_d == ST_CHK);
        rpc_d  = (state_d == ST_DONE);
        err_d  = (state_d == ST_ERR);
    end

    // State and output registers; reset drops everything asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_lo_q <= 8'd0;
            last_q   <= '0;
            idx_q    <= '0;
            bsel_q   <= 2'd0;
            asm_q    <= 24'd0;
            sum_q    <= 8'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= 32'd0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
            rpc_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_lo_q <= cnt_lo_d;
            last_q   <= last_d;
            idx_q    <= idx_d;
            bsel_q   <= bsel_d;
            asm_q    <= asm_d;
            sum_q    <= sum_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
            rpc_q    <= rpc_d;
            err_q    <= err_d;
        end
    end

    assign rx_ready = rdy_q;
    assign we0      = we_q;
    assign wr_addr0 = addr_q;
    assign wr_din0  = din_q;
    assign resetpc  = rpc_q;
    assign busy     = busy_q;
    assign error    = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: frames are built and their
// expected writes/outcome derived from the frame rules, then compared with
// a monitor that records every write strobe.
module tb_imem_boot_loader;

    localparam int ADDR_W = 9;
    localparam int MAXW   = 128;

    typedef logic [ADDR_W+31:0] wr_t;

    logic              clk;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              we0;
    logic [ADDR_W-1:0] wr_addr0;
    logic [31:0]       wr_din0;
    logic              resetpc;
    logic              busy;
    logic              error;

    int checks   = 0;
    int failures = 0;

    logic [31:0] words_q[$];
    logic [7:0]  frame_q[$];
    wr_t         exp_q[$];
    wr_t         cap_q[$];
    logic        exp_done;

    int cyc = 0;
    int last_we = -100;
    int spacing_viol = 0;

    imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW)) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .we0      (we0),
        .wr_addr0 (wr_addr0),
        .wr_din0  (wr_din0),
        .resetpc  (resetpc),
        .busy     (busy),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Write monitor: records each strobe and checks pulse spacing.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (we0 === 1'b1) begin
            cap_q.push_back({wr_addr0, wr_din0});
            if (cyc - last_we < 4) spacing_viol = spacing_viol + 1;
            last_we = cyc;
        end
    end

    // Build frame bytes, expected writes and expected outcome from words_q.
    task automatic build_frame(input logic [15:0] n, input logic [7:0] chk_delta);
        logic [7:0] s;
        logic       ok;
        frame_q.delete();
        exp_q.delete();
        frame_q.push_back(n[7:0]);
        frame_q.push_back(n[15:8]);
        s  = n[7:0] + n[15:8];
        ok = (n >= 16'd1) && (n <= 16'(MAXW));
        foreach (words_q[i]) begin
            for (int b = 0; b < 4; b++) begin
                frame_q.push_back(words_q[i][8*b +: 8]);
                s = s + words_q[i][8*b +: 8];
            end
            if (ok) exp_q.push_back({ADDR_W'(4*i), words_q[i]});
        end
        frame_q.push_back(s + chk_delta);
        exp_done = ok && (chk_delta == 8'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic send_range(input int lo, input int hi, input int maxgap);
        for (int i = lo; i <= hi; i++) send_byte(frame_q[i], $urandom_range(0, maxgap));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic assert_reset();
        @(negedge clk);
        #1;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        cap_q.delete();
        last_we = -100;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        assert_reset();
        checks++; if ({rx_ready, we0, resetpc, busy, error} !== 5'b0) begin
            failures++; $display("FAIL reset_flags got=%b want=00000", {rx_ready, we0, resetpc, busy, error});
        end
        checks++; if ({wr_addr0, wr_din0} !== '0) begin
            failures++; $display("FAIL reset_bus got=%h/%h want=0/0", wr_addr0, wr_din0);
        end
        release_reset();
        checks++; if (rx_ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL idle_ready got rdy=%b busy=%b want 1 0", rx_ready, busy);
        end
    endtask

    task automatic test_nominal();
        assert_reset(); release_reset();
        words_q.delete();
        words_q.push_back(32'h00000013);
        for (int i = 1; i < 9; i++) words_q.push_back($urandom());
        build_frame(16'd9, 8'd0);
        send_range(0, frame_q.size() - 2, 0);
        idle(1);
        checks++; if (resetpc !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL nom_prechk got rpc=%b busy=%b want 0 1", resetpc, busy);
        end
        send_byte(frame_q[frame_q.size() - 1], 0);
        idle(1);
        checks++; if (resetpc !== 1'b1 || error !== 1'b0 || rx_ready !== 1'b0) begin
            failures++; $display("FAIL nom_done got rpc=%b err=%b rdy=%b want 1 0 0", resetpc, error, rx_ready);
        end
        idle(2);
        checks++; if (cap_q.size() !== exp_q.size()) begin
            failures++; $display("FAIL nom_nwrites got=%0d want=%0d", cap_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (cap_q[i] !== exp_q[i]) begin
                    failures++; $display("FAIL nom_write%0d got=%h want=%h", i, cap_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_bad_chk();
        int n0;
        assert_reset(); release_reset();
        build_frame(16'd9, 8'd1);
        send_range(0, frame_q.size() - 1, 1);
        idle(2);
        checks++; if (error !== 1'b1 || resetpc !== 1'b0 || rx_ready !== 1'b0) begin
            failures++; $display("FAIL badchk_flags got err=%b rpc=%b rdy=%b want 1 0 0", error, resetpc, rx_ready);
        end
        checks++; if (cap_q.size() !== 9) begin
            failures++; $display("FAIL badchk_nwrites got=%0d want=9", cap_q.size());
        end
        n0 = cap_q.size();
        send_range(0, 7, 0);
        idle(3);
        checks++; if (cap_q.size() !== n0 || error !== 1'b1) begin
            failures++; $display("FAIL badchk_ignored got writes=%0d err=%b want %0d 1", cap_q.size(), error, n0);
        end
    endtask

    task automatic test_count_bounds();
        // N = 0: rejected on the high count byte.
        assert_reset(); release_reset();
        words_q.delete();
        build_frame(16'd0, 8'd0);
        send_range(0, 1, 0);
        idle(1);
        checks++; if (error !== 1'b1 || busy !== 1'b0 || rx_ready !== 1'b0) begin
            failures++; $display("FAIL n0_err got err=%b busy=%b rdy=%b want 1 0 0", error, busy, rx_ready);
        end
        send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        idle(2);
        checks++; if (cap_q.size() !== 0) begin
            failures++; $display("FAIL n0_nwrites got=%0d want=0", cap_q.size());
        end
        // N = 129: one above capacity.
        assert_reset(); release_reset();
        build_frame(16'd129, 8'd0);
        send_range(0, 1, 0);
        idle(1);
        checks++; if (error !== 1'b1) begin
            failures++; $display("FAIL n129_err got=%b want=1", error);
        end
        // N = 256 (low byte zero) must also be rejected.
        assert_reset(); release_reset();
        build_frame(16'd256, 8'd0);
        send_range(0, 1, 0);
        idle(1);
        checks++; if (error !== 1'b1) begin
            failures++; $display("FAIL n256_err got=%b want=1", error);
        end
    endtask

    task automatic test_back_to_back();
        assert_reset(); release_reset();
        spacing_viol = 0;
        words_q.delete();
        for (int i = 0; i < MAXW; i++) words_q.push_back($urandom());
        build_frame(16'(MAXW), 8'd0);
        send_range(0, frame_q.size() - 1, 0);
        idle(2);
        checks++; if (resetpc !== 1'b1 || error !== 1'b0) begin
            failures++; $display("FAIL n128_done got rpc=%b err=%b want 1 0", resetpc, error);
        end
        checks++; if (cap_q.size() !== MAXW) begin
            failures++; $display("FAIL n128_nwrites got=%0d want=%0d", cap_q.size(), MAXW);
        end else begin
            checks++; if (cap_q[MAXW-1] !== exp_q[MAXW-1] || cap_q[MAXW-1][ADDR_W+31:32] !== 9'd508) begin
                failures++; $display("FAIL n128_last got=%h want=%h", cap_q[MAXW-1], exp_q[MAXW-1]);
            end
            for (int i = 0; i < MAXW; i++) begin
                if (cap_q[i] !== exp_q[i]) begin
                    checks++; failures++;
                    $display("FAIL n128_write%0d got=%h want=%h", i, cap_q[i], exp_q[i]);
                end
            end
        end
        checks++; if (spacing_viol !== 0) begin
            failures++; $display("FAIL we_spacing got=%0d violations want=0", spacing_viol);
        end
    endtask

    task automatic test_byte_order_gaps();
        assert_reset(); release_reset();
        words_q.delete();
        words_q.push_back(32'hDEADBEEF);
        build_frame(16'd1, 8'd0);
        send_range(0, 5, 5);
        idle(1);
        checks++; if (we0 !== 1'b1 || wr_addr0 !== 9'd0 || wr_din0 !== 32'hDEADBEEF) begin
            failures++; $display("FAIL order_write got we=%b a=%h d=%h want 1 0 deadbeef", we0, wr_addr0, wr_din0);
        end
        idle(1);
        checks++; if (we0 !== 1'b0 || wr_din0 !== 32'hDEADBEEF) begin
            failures++; $display("FAIL order_pulse got we=%b d=%h want 0 deadbeef", we0, wr_din0);
        end
        send_byte(frame_q[6], $urandom_range(0, 5));
        idle(1);
        checks++; if (resetpc !== 1'b1 || cap_q.size() !== 1) begin
            failures++; $display("FAIL order_done got rpc=%b writes=%0d want 1 1", resetpc, cap_q.size());
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] w2;
        assert_reset(); release_reset();
        words_q.delete();
        for (int i = 0; i < 5; i++) words_q.push_back($urandom() | 32'h1);
        w2 = words_q[2];
        build_frame(16'd5, 8'd0);
        send_range(0, 15, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        checks++; if (cap_q.size() !== 3 || wr_addr0 !== 9'd8 || wr_din0 !== w2) begin
            failures++; $display("FAIL mid_prereset got writes=%0d a=%h d=%h want 3 8 %h", cap_q.size(), wr_addr0, wr_din0, w2);
        end
        #1 reset = 1'b1;
        #1;
        checks++; if ({rx_ready, we0, resetpc, busy, error} !== 5'b0 || {wr_addr0, wr_din0} !== '0) begin
            failures++; $display("FAIL mid_async got flags=%b a=%h d=%h want 0 0 0", {rx_ready, we0, resetpc, busy, error}, wr_addr0, wr_din0);
        end
        release_reset();
        words_q.delete();
        words_q.push_back($urandom()); words_q.push_back($urandom());
        build_frame(16'd2, 8'd0);
        send_range(0, frame_q.size() - 1, 2);
        idle(2);
        checks++; if (resetpc !== 1'b1 || cap_q.size() !== 2) begin
            failures++; $display("FAIL mid_fresh got rpc=%b writes=%0d want 1 2", resetpc, cap_q.size());
        end else begin
            checks++; if (cap_q[0] !== exp_q[0] || cap_q[1] !== exp_q[1]) begin
                failures++; $display("FAIL mid_fresh_data got=%h,%h want=%h,%h", cap_q[0], cap_q[1], exp_q[0], exp_q[1]);
            end
        end
    endtask

    task automatic test_chk_wrap();
        assert_reset(); release_reset();
        words_q.delete();
        for (int i = 0; i < 4; i++) words_q.push_back(32'hFFFFFFFF);
        build_frame(16'd4, 8'd0);
        frame_q[frame_q.size() - 1] = 8'hF4;
        send_range(0, frame_q.size() - 1, 0);
        idle(1);
        checks++; if (resetpc !== 1'b1 || error !== 1'b0) begin
            failures++; $display("FAIL wrap_done got rpc=%b err=%b want 1 0", resetpc, error);
        end
    endtask

    task automatic test_random_frames();
        int n;
        logic [7:0] d;
        for (int f = 0; f < 6; f++) begin
            assert_reset(); release_reset();
            n = $urandom_range(1, 12);
            d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            words_q.delete();
            for (int i = 0; i < n; i++) words_q.push_back($urandom());
            build_frame(16'(n), d);
            send_range(0, frame_q.size() - 1, 3);
            idle(2);
            checks++; if (resetpc !== exp_done || error !== !exp_done) begin
                failures++; $display("FAIL rand%0d_status got rpc=%b err=%b want %b %b", f, resetpc, error, exp_done, !exp_done);
            end
            checks++; if (cap_q.size() !== exp_q.size()) begin
                failures++; $display("FAIL rand%0d_nwrites got=%0d want=%0d", f, cap_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++; if (cap_q[i] !== exp_q[i]) begin
                        failures++; $display("FAIL rand%0d_write%0d got=%h want=%h", f, i, cap_q[i], exp_q[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        clk      = 1'b0;
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        test_reset();
        test_nominal();
        test_bad_chk();
        test_count_bounds();
        test_byte_order_gaps();
        test_reset_midframe();
        test_chk_wrap();
        test_back_to_back();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
